// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants for the 6502 cycle sequencer and its helpers.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [1:0] NS_INC    = 2'b00;
  localparam logic [1:0] NS_FETCH  = 2'b01;
  localparam logic [1:0] NS_SKIP   = 2'b10;
  localparam logic [1:0] NS_BRANCH = 2'b11;

  localparam logic [1:0] ENTRY_SW  = 2'b00;
  localparam logic [1:0] ENTRY_IRQ = 2'b01;
  localparam logic [1:0] ENTRY_NMI = 2'b10;
  localparam logic [1:0] ENTRY_RST = 2'b11;

  localparam logic [7:0] OP_BRK = 8'h00;

  localparam int KIL_COUNT = 12;
  localparam logic [7:0] KIL_OPCODES [KIL_COUNT] = '{
    8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 8'h52,
    8'h62, 8'h72, 8'h92, 8'hB2, 8'hD2, 8'hF2
  };

  function automatic logic is_kil(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < KIL_COUNT; k++) begin
      if (op == KIL_OPCODES[k]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_cycle_sequencer_if
// Brief    : Bundle between the cycle sequencer and the microcode/bus side.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_cycle_sequencer_if;

  logic       ce;
  logic [1:0] next_state;
  logic [7:0] din;
  logic       branch_taken;
  logic       page_cross;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  logic [7:0] ir;
  logic [2:0] state;
  logic       sync;
  logic [1:0] int_entry;
  logic       reset_active;
  logic       jammed;

  modport master (
    output ce, next_state, din, branch_taken, page_cross, nmi_n, irq_n, i_flag,
    input  ir, state, sync, int_entry, reset_active, jammed
  );

  modport slave (
    input  ce, next_state, din, branch_taken, page_cross, nmi_n, irq_n, i_flag,
    output ir, state, sync, int_entry, reset_active, jammed
  );

endinterface
`default_nettype wire

// File: rtl/cpu_int_latch.sv
`default_nettype none
// ============================================================================
// Module   : cpu_int_latch
// Brief    : NMI edge latch plus IRQ qualification; emits a prioritised code.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_int_latch
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic       nmi_take,
  output logic [1:0] pending
);

  logic r_nmi_prev;
  logic r_nmi_latch;
  logic w_nmi_fall;

  assign w_nmi_fall = r_nmi_prev & ~nmi_n;

  // A fresh falling edge wins over consumption so back-to-back NMIs are kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nmi_prev  <= 1'b1;
      r_nmi_latch <= 1'b0;
    end else if (ce) begin
      r_nmi_prev  <= nmi_n;
      r_nmi_latch <= w_nmi_fall | (r_nmi_latch & ~nmi_take);
    end
  end

  always_comb begin
    pending = ENTRY_SW;
    if (reset)                  pending = ENTRY_RST;
    else if (r_nmi_latch)       pending = ENTRY_NMI;
    else if (!irq_n && !i_flag) pending = ENTRY_IRQ;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_cycle_sequencer
// Brief    : Owns {ir, state} for the microcode table; injects BRK on entry.
//            Optional KIL jam detection under `CPU_JAM_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int RESET_VECTOR_CYCLES = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_cycle_sequencer_if.slave  bus
);

  localparam int               c_cnt_w    = $clog2(RESET_VECTOR_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RESET_VECTOR_CYCLES - 1);

  logic [7:0]         r_ir;
  logic [2:0]         r_state;
  logic               r_sync;
  logic [1:0]         r_entry;
  logic               r_reset_active;
  logic [c_cnt_w-1:0] r_rst_cnt;

  logic [1:0]         w_pending;
  logic               w_fetch;
  logic               w_jam_hold;
  logic               w_nmi_take;

  cpu_int_latch u_int_latch (
    .clk      (clk),
    .reset    (reset),
    .ce       (bus.ce),
    .nmi_n    (bus.nmi_n),
    .irq_n    (bus.irq_n),
    .i_flag   (bus.i_flag),
    .nmi_take (w_nmi_take),
    .pending  (w_pending)
  );

  // A not-taken branch is the next opcode fetch.
  always_comb begin
    w_fetch = (bus.next_state == NS_FETCH) ||
              ((bus.next_state == NS_BRANCH) && !bus.branch_taken);
  end

  assign w_nmi_take = bus.ce && w_fetch && !w_jam_hold && (w_pending == ENTRY_NMI);

`ifdef CPU_JAM_DETECT_EN
  logic r_jammed;

  // The edge after a KIL fetch freezes the sequencer until reset.
  always_comb begin
    w_jam_hold = r_jammed || (r_sync && is_kil(r_ir));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_jammed <= 1'b0;
    end else if (bus.ce && w_jam_hold) begin
      r_jammed <= 1'b1;
    end
  end

  assign bus.jammed = r_jammed;
`else
  assign w_jam_hold = 1'b0;
  assign bus.jammed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir           <= OP_BRK;
      r_state        <= 3'd0;
      r_sync         <= 1'b0;
      r_entry        <= ENTRY_RST;
      r_reset_active <= 1'b1;
      r_rst_cnt      <= '0;
    end else if (bus.ce) begin
      if (r_reset_active) begin
        r_rst_cnt <= r_rst_cnt + 1'b1;
        if (w_fetch || (r_rst_cnt == c_cnt_last)) r_reset_active <= 1'b0;
      end

      r_sync <= 1'b0;
      if (w_jam_hold) begin
        r_state <= 3'd1;
      end else if (w_fetch) begin
        r_state <= 3'd0;
        r_sync  <= 1'b1;
        r_entry <= w_pending;
        if (w_pending == ENTRY_SW) r_ir <= bus.din;
        else                       r_ir <= OP_BRK;
      end else begin
        case (bus.next_state)
          NS_SKIP: r_state <= bus.page_cross ? (r_state + 3'd1) : (r_state + 3'd2);
          default: r_state <= r_state + 3'd1;
        endcase
      end
    end
  end

  assign bus.ir           = r_ir;
  assign bus.state        = r_state;
  assign bus.sync         = r_sync;
  assign bus.int_entry    = r_entry;
  assign bus.reset_active = r_reset_active;

endmodule
`default_nettype wire

// File: tb/tb_cpu_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_cycle_sequencer
// Brief    : Directed vector table plus hand sequences for the cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_cycle_sequencer;
  import cpu_pkg::*;

  typedef struct {
    logic [1:0] ns;
    logic [7:0] din;
    logic       bt;
    logic       pc;
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic [7:0] e_ir;
    logic [2:0] e_state;
    logic       e_sync;
    logic [1:0] e_entry;
    logic       e_ra;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  vec_t vecs[$];

  cpu_cycle_sequencer_if bus ();

  cpu_cycle_sequencer #(.RESET_VECTOR_CYCLES(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] ns, input logic [7:0] din,
                              input logic bt, input logic pc, input logic nmi_n,
                              input logic irq_n, input logic i_flag,
                              input logic [7:0] e_ir, input logic [2:0] e_state,
                              input logic e_sync, input logic [1:0] e_entry,
                              input logic e_ra);
    vec_t v;
    v.ns = ns; v.din = din; v.bt = bt; v.pc = pc;
    v.nmi_n = nmi_n; v.irq_n = irq_n; v.i_flag = i_flag;
    v.e_ir = e_ir; v.e_state = e_state; v.e_sync = e_sync;
    v.e_entry = e_entry; v.e_ra = e_ra;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_core(input string tag, input logic [7:0] e_ir, input logic [2:0] e_state,
                          input logic e_sync, input logic [1:0] e_entry);
    chk({tag, ".ir"},        32'(bus.ir),        32'(e_ir));
    chk({tag, ".state"},     32'(bus.state),     32'(e_state));
    chk({tag, ".sync"},      32'(bus.sync),      32'(e_sync));
    chk({tag, ".int_entry"}, 32'(bus.int_entry), 32'(e_entry));
  endtask

  task automatic drive(input logic [1:0] ns, input logic [7:0] din, input logic bt,
                       input logic pc, input logic nmi_n, input logic irq_n, input logic i_flag);
    bus.next_state   = ns;
    bus.din          = din;
    bus.branch_taken = bt;
    bus.page_cross   = pc;
    bus.nmi_n        = nmi_n;
    bus.irq_n        = irq_n;
    bus.i_flag       = i_flag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset BRK run, then normal fetches, branches, skips and interrupt entry.
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(NS_INC, 8'h00, 0, 0, 1, 1, 0, 8'h00, 3'(i + 1), 0, ENTRY_RST, (i < 6)));
    vecs.push_back(mk(NS_FETCH,  8'hA9, 0, 0, 1, 1, 0, 8'hA9, 3'd0, 1, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'hA9, 3'd1, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_FETCH,  8'hD0, 0, 0, 1, 1, 0, 8'hD0, 3'd0, 1, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'hD0, 3'd1, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_BRANCH, 8'h99, 1, 0, 1, 1, 0, 8'hD0, 3'd2, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'hD0, 3'd3, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_SKIP,   8'h00, 0, 0, 1, 1, 0, 8'hD0, 3'd5, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_FETCH,  8'hD0, 0, 0, 1, 1, 0, 8'hD0, 3'd0, 1, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'hD0, 3'd1, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_BRANCH, 8'h4C, 0, 0, 1, 1, 0, 8'h4C, 3'd0, 1, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'h4C, 3'd1, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'h4C, 3'd2, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'h4C, 3'd3, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_SKIP,   8'h00, 0, 1, 1, 1, 0, 8'h4C, 3'd4, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_FETCH,  8'hEA, 0, 0, 1, 0, 1, 8'hEA, 3'd0, 1, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 0, 1, 8'hEA, 3'd1, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 0, 0, 0, 8'hEA, 3'd2, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 0, 0, 8'hEA, 3'd3, 0, ENTRY_SW,  0));
    vecs.push_back(mk(NS_FETCH,  8'h55, 0, 0, 1, 0, 0, 8'h00, 3'd0, 1, ENTRY_NMI, 0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 0, 0, 8'h00, 3'd1, 0, ENTRY_NMI, 0));
    vecs.push_back(mk(NS_FETCH,  8'h55, 0, 0, 1, 0, 0, 8'h00, 3'd0, 1, ENTRY_IRQ, 0));
    vecs.push_back(mk(NS_FETCH,  8'h55, 0, 0, 1, 1, 0, 8'h55, 3'd0, 1, ENTRY_SW,  0));
    vecs.push_back(mk(NS_INC,    8'h00, 0, 0, 1, 1, 0, 8'h55, 3'd1, 0, ENTRY_SW,  0));

    bus.ce = 1'b1;
    drive(NS_FETCH, 8'hFF, 0, 0, 1, 1, 0);
    reset = 1'b1;
    step();
    chk_core("reset", 8'h00, 3'd0, 1'b0, ENTRY_RST);
    chk("reset.reset_active", 32'(bus.reset_active), 32'd1);
    chk("reset.jammed",       32'(bus.jammed),       32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ns, vecs[i].din, vecs[i].bt, vecs[i].pc,
            vecs[i].nmi_n, vecs[i].irq_n, vecs[i].i_flag);
      step();
      chk_core($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_state,
               vecs[i].e_sync, vecs[i].e_entry);
      chk($sformatf("vec%0d.reset_active", i), 32'(bus.reset_active), 32'(vecs[i].e_ra));
    end

    // Clock enable low: nothing moves and the NMI edge is not seen.
    bus.ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(NS_FETCH, 8'h11, 0, 0, (k >= 2), 1, 0);
      step();
      chk_core($sformatf("ce_low%0d", k), 8'h55, 3'd1, 1'b0, ENTRY_SW);
    end
    bus.ce = 1'b1;
    drive(NS_FETCH, 8'h11, 0, 0, 1, 1, 0);
    step();
    chk_core("ce_resume", 8'h11, 3'd0, 1'b1, ENTRY_SW);

    // New NMI edge on the same cycle the latch is consumed.
    drive(NS_INC, 8'h00, 0, 0, 0, 1, 0);   step();
    drive(NS_INC, 8'h00, 0, 0, 1, 1, 0);   step();
    drive(NS_FETCH, 8'h33, 0, 0, 0, 1, 0); step();
    chk_core("nmi_coinc_a", 8'h00, 3'd0, 1'b1, ENTRY_NMI);
    drive(NS_FETCH, 8'h33, 0, 0, 1, 1, 0); step();
    chk_core("nmi_coinc_b", 8'h00, 3'd0, 1'b1, ENTRY_NMI);
    drive(NS_FETCH, 8'h33, 0, 0, 1, 1, 0); step();
    chk_core("nmi_coinc_c", 8'h33, 3'd0, 1'b1, ENTRY_SW);

    // Counter wraps 7 -> 0 without touching ir.
    drive(NS_INC, 8'hAA, 0, 0, 1, 1, 0);
    for (int k = 0; k < 7; k++) step();
    chk("wrap.state7", 32'(bus.state), 32'd7);
    step();
    chk_core("wrap", 8'h33, 3'd0, 1'b0, ENTRY_SW);

    // KIL opcode fetch.
    drive(NS_FETCH, 8'h02, 0, 0, 1, 1, 0); step();
    chk_core("kil_fetch", 8'h02, 3'd0, 1'b1, ENTRY_SW);
    drive(NS_INC, 8'h00, 0, 0, 0, 1, 0);   step();
    chk("kil_next.state", 32'(bus.state), 32'd1);
`ifdef CPU_JAM_DETECT_EN
    chk("kil_next.jammed", 32'(bus.jammed), 32'd1);
    drive(NS_FETCH, 8'hEA, 0, 0, 1, 0, 0); step();
    chk_core("jam_hold", 8'h02, 3'd1, 1'b0, ENTRY_SW);
    chk("jam_hold.jammed", 32'(bus.jammed), 32'd1);
`else
    chk("kil_next.jammed", 32'(bus.jammed), 32'd0);
    drive(NS_INC, 8'h00, 0, 0, 1, 1, 0);   step();
    chk_core("kil_follow", 8'h02, 3'd2, 1'b0, ENTRY_SW);
    chk("kil_follow.jammed", 32'(bus.jammed), 32'd0);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("jam_clear.jammed", 32'(bus.jammed), 32'd0);
    chk_core("jam_clear", 8'h00, 3'd0, 1'b0, ENTRY_RST);

    // Early fetch ends the reset entry before the cycle budget runs out.
    drive(NS_INC, 8'h00, 0, 0, 1, 1, 0);
    step(); step();
    chk("early.reset_active_before", 32'(bus.reset_active), 32'd1);
    drive(NS_FETCH, 8'h20, 0, 0, 1, 1, 0); step();
    chk("early.reset_active_after", 32'(bus.reset_active), 32'd0);
    chk_core("early", 8'h20, 3'd0, 1'b1, ENTRY_SW);

    // Reset mid-instruction with ce low overrides the pending fetch.
    drive(NS_INC, 8'h00, 0, 0, 1, 1, 0); step();
    bus.ce = 1'b0;
    drive(NS_FETCH, 8'h77, 0, 0, 1, 1, 0);
    reset = 1'b1;
    step();
    chk_core("mid_reset", 8'h00, 3'd0, 1'b0, ENTRY_RST);
    chk("mid_reset.reset_active", 32'(bus.reset_active), 32'd1);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_cycle_sequencer.md
Name: cpu_cycle_sequencer

Overview:
- Upstream stage of the 6502 microcode table in the NES CPU core.
- Owns the instruction register `ir[7:0]` and the cycle counter `state[2:0]`. Together these form the table's address.
- Consumes the 2-bit NextState field the table returns, together with the data-bus byte, branch/page-cross conditions and interrupt lines. From these it decides the next `{ir, state}`.
- Injects opcode 0x00 (BRK) for reset, NMI and IRQ entry, and flags which source caused the entry.

Parameters:
- RESET_VECTOR_CYCLES, 7, number of cycles the reset-entry BRK sequence runs with writes suppressed (`reset_active` high).

Ports:
- `clk` input 1 system clock
- `reset` input 1 synchronous, active-high reset
- `ce` input 1 clock enable; all state advances only when high
- `next_state` input 2 NextState field from the microcode table
- `din` input 8 data-bus byte, valid during an opcode-fetch cycle
- `branch_taken` input 1 branch condition for the current branch opcode
- `page_cross` input 1 address-add carry of the current indexed/branch cycle
- `nmi_n` input 1 NMI line, active low, edge-triggered
- `irq_n` input 1 IRQ line, active low, level
- `i_flag` input 1 processor I flag; masks IRQ
- `ir` output 8 instruction register
- `state` output 3 cycle within the instruction
- `sync` output 1 high while the current cycle is an opcode fetch
- `int_entry` output 2 source of the current BRK: 00 software, 01 IRQ, 10 NMI, 11 reset
- `reset_active` output 1 high during reset entry; downstream suppresses bus writes
- `jammed` output 1 sequencer halted on a KIL opcode (see Optional Feature)

Behaviour:
- Reset values (reset high on a clk edge, regardless of `ce`):
  - `ir` = 0x00, `state` = 0, `sync` = 0
  - `int_entry` = 11, `reset_active` = 1
  - `nmi` edge latch = 0, `nmi_n` delay register = 1, `jammed` = 0
- When `ce` is low, all registers hold and edge detection is frozen.
- All decisions below are evaluated on a clk edge with `ce` high.
- NextState decode:
  - 00: `state` <= `state` + 1. From 7 it wraps to 0 without loading `ir` (illegal microcode; the bench flags it).
  - 01 (fetch): `state` <= 0, `sync` <= 1 for the new cycle, and `ir` loads as follows:
    - reset pending: 0x00
    - else NMI latched: 0x00, `int_entry` = 10, latch cleared
    - else `irq_n` low and `i_flag` low: 0x00, `int_entry` = 01
    - else `ir` <= `din`, `int_entry` = 00
  - 10 (skip-if-no-carry): `state` <= `state` + 2 if `page_cross` = 0, else `state` + 1.
  - 11 (branch): if `branch_taken` = 0, behave as 01. Otherwise `state` <= `state` + 1.
- `sync` is 0 on every cycle not entered via fetch.
- Interrupt priority: reset > NMI > IRQ. An interrupt is sampled only at fetch.
- NMI latch:
  - Set on a falling edge of `nmi_n` (registered previous value 1, current value 0).
  - Stays set until it is consumed at a fetch.
  - If a new falling edge and consumption coincide, the latch stays set.
- IRQ is level-sampled. If IRQ is deasserted before a fetch, no entry occurs.
- Reset entry:
  - `reset_active` stays 1 until RESET_VECTOR_CYCLES `ce` cycles have elapsed, or until the first fetch, whichever is first. It then drops to 0.
  - `int_entry` holds 11 until the next fetch.
- Reset asserted mid-instruction: takes effect on the same edge, overriding any `next_state`.

Optional Feature:
- Macro: `CPU_JAM_DETECT_EN`
- With the macro:
  - A fetch that loads one of the KIL opcodes (0x02, 0x12, 0x22, 0x32, 0x42, 0x52, 0x62, 0x72, 0x92, 0xB2, 0xD2, 0xF2) sets `jammed` to 1 on the following edge.
  - While jammed, `state` holds at 1, `ir` holds, and NMI/IRQ are ignored.
  - Only reset clears the jam.
- Without the macro: `jammed` is tied 0 and KIL opcodes follow the microcode.

Decomposition:
- Shared package `cpu_pkg`:
  - NextState encoding constants: NS_INC, NS_FETCH, NS_SKIP, NS_BRANCH
  - `int_entry` codes: ENTRY_SW, ENTRY_IRQ, ENTRY_NMI, ENTRY_RST
  - the BRK opcode constant
  - the KIL opcode list
- One natural sub-module: `cpu_int_latch`. It holds the NMI edge detector and latch plus the IRQ qualification, and outputs a prioritised pending code.

Test Plan:
- Reset, then 7 `ce` cycles with `next_state` 00, then 01 with `din` = 0xA9:
  - `ir` stays 0x00 with `state` 0..6 during the run
  - `reset_active` is 1 through the run and drops at the fetch
  - after the fetch: `ir` = 0xA9, `state` = 0, `sync` = 1, `int_entry` = 00
- Branch opcode 0xD0 at `state` 1, NextState 11:
  - `branch_taken` = 0: `state` = 0, `ir` = `din`
  - `branch_taken` = 1: `state` = 2
- NextState 10 at `state` 3:
  - `page_cross` = 0: `state` = 5
  - `page_cross` = 1: `state` = 4
- `nmi_n` pulsed low for one cycle mid-instruction, with `irq_n` also low:
  - at the next fetch, `ir` = 0x00 and `int_entry` = 10
  - at the following fetch, `int_entry` = 01
- `irq_n` low with `i_flag` = 1 at fetch:
  - `ir` = `din` (0xEA), `int_entry` = 00
- `ce` held low for 5 cycles while `nmi_n` falls and returns high:
  - no state change and no latch set
- With `CPU_JAM_DETECT_EN`, fetch `din` = 0x02:
  - `jammed` = 1 and `state` frozen at 1 despite NMI
  - reset clears `jammed` to 0
